// File: rtl/cool_proc_pkg.sv
// Shared definitions for the register-bank read path: FSM encoding, beat tags
// and the one-hot check used on every select and write-enable vector.
package cool_proc_pkg;

    localparam int NREGS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD_A = 2'd1,
        ST_RD_B = 2'd2
    } state_t;

    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

    function automatic logic is_onehot(input logic [NREGS-1:0] v);
        return (v != '0) && ((v & (v - {{(NREGS-1){1'b0}}, 1'b1})) == '0);
    endfunction

endpackage

// File: rtl/reg_onehot_select.sv
// Combinational one-hot register mux with write forwarding: a same-cycle bank
// write to the selected register wins over the (about to be stale) q value.
module reg_onehot_select
    import cool_proc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [NREGS-1:0] sel,
    input  logic [WIDTH-1:0] q0,
    input  logic [WIDTH-1:0] q1,
    input  logic [WIDTH-1:0] q2,
    input  logic [WIDTH-1:0] q3,
    input  logic [WIDTH-1:0] q4,
    input  logic [WIDTH-1:0] q5,
    input  logic [WIDTH-1:0] q6,
    input  logic [WIDTH-1:0] q7,
    input  logic [NREGS-1:0] wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] value,
    output logic             sel_ok
);

    logic [WIDTH-1:0] q_arr [NREGS];

    assign q_arr[0] = q0;
    assign q_arr[1] = q1;
    assign q_arr[2] = q2;
    assign q_arr[3] = q3;
    assign q_arr[4] = q4;
    assign q_arr[5] = q5;
    assign q_arr[6] = q6;
    assign q_arr[7] = q7;

    assign sel_ok = is_onehot(sel);

    // The bank ignores zero or multi-hot write enables, so only a clean one-hot write forwards.
    always_comb begin
        value = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (sel[i]) begin
                value = value | q_arr[i];
            end
        end
        if (is_onehot(wr_en) && (wr_en == sel)) begin
            value = wr_data;
        end
    end

endmodule

// File: rtl/register_reader.sv
// Reads an operand pair (A then B) from the register bank and serialises it
// onto the shared operand bus as two tagged beats; all outputs are registered.
module register_reader
    import cool_proc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [NREGS-1:0] sel_a,
    input  logic [NREGS-1:0] sel_b,
    input  logic [WIDTH-1:0] q0,
    input  logic [WIDTH-1:0] q1,
    input  logic [WIDTH-1:0] q2,
    input  logic [WIDTH-1:0] q3,
    input  logic [WIDTH-1:0] q4,
    input  logic [WIDTH-1:0] q5,
    input  logic [WIDTH-1:0] q6,
    input  logic [WIDTH-1:0] q7,
    input  logic [NREGS-1:0] wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid,
    output logic             bus_tag,
    output logic             busy,
    output logic             done,
    output logic             sel_err
);

    state_t           state_q, state_d;
    logic [NREGS-1:0] sel_a_q, sel_a_d;
    logic [NREGS-1:0] sel_b_q, sel_b_d;
    logic [WIDTH-1:0] bus_out_q, bus_out_d;
    logic             bus_valid_q, bus_valid_d;
    logic             bus_tag_q, bus_tag_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0] value_a, value_b;
    logic             ok_a, ok_b;
    logic             start_ok;

    assign start_ok = is_onehot(sel_a) && is_onehot(sel_b);

    reg_onehot_select #(.WIDTH(WIDTH)) u_sel_a (
        .sel(sel_a_q), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .q4(q4), .q5(q5), .q6(q6), .q7(q7),
        .wr_en(wr_en), .wr_data(wr_data), .value(value_a), .sel_ok(ok_a)
    );

    reg_onehot_select #(.WIDTH(WIDTH)) u_sel_b (
        .sel(sel_b_q), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .q4(q4), .q5(q5), .q6(q6), .q7(q7),
        .wr_en(wr_en), .wr_data(wr_data), .value(value_b), .sel_ok(ok_b)
    );

    always_comb begin
        state_d     = state_q;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        bus_out_d   = '0;
        bus_valid_d = 1'b0;
        bus_tag_d   = TAG_A;
        done_d      = 1'b0;
        sel_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        sel_a_d = sel_a;
                        sel_b_d = sel_b;
                        state_d = ST_RD_A;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            ST_RD_A: begin
                bus_out_d   = ok_a ? value_a : '0;
                bus_valid_d = ok_a;
                bus_tag_d   = TAG_A;
                state_d     = ST_RD_B;
            end
            ST_RD_B: begin
                bus_out_d   = ok_b ? value_b : '0;
                bus_valid_d = ok_b;
                bus_tag_d   = TAG_B;
                done_d      = 1'b1;
                state_d     = ST_IDLE;
                // Accepting here chains pairs without a bus bubble; a bad select is
                // dropped silently so sel_err never collides with done.
                if (start && start_ok) begin
                    sel_a_d = sel_a;
                    sel_b_d = sel_b;
                    state_d = ST_RD_A;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            sel_a_q     <= '0;
            sel_b_q     <= '0;
            bus_out_q   <= '0;
            bus_valid_q <= 1'b0;
            bus_tag_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
            bus_tag_q   <= bus_tag_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus_out   = bus_out_q;
    assign bus_valid = bus_valid_q;
    assign bus_tag   = bus_tag_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_register_reader.sv
// Self-checking bench for register_reader: directed scenarios plus randomized
// traffic compared every cycle against a beat-scheduling reference model.
module tb_register_reader;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [7:0]  sel_a, sel_b;
    logic [15:0] q [8];
    logic [7:0]  wr_en;
    logic [15:0] wr_data;
    logic [15:0] bus_out;
    logic        bus_valid, bus_tag, busy, done, sel_err;

    int total = 0;
    int bad = 0;
    int cycle = 0;

    // Reference model: edges elapsed since the last accepted start plus the latched pair.
    int          since_acc = 99;
    logic [7:0]  lat_a = 8'h00;
    logic [7:0]  lat_b = 8'h00;
    logic [15:0] exp_out;
    logic        exp_valid, exp_tag, exp_busy, exp_done, exp_err;

    register_reader #(.WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .start(start), .sel_a(sel_a), .sel_b(sel_b),
        .q0(q[0]), .q1(q[1]), .q2(q[2]), .q3(q[3]),
        .q4(q[4]), .q5(q[5]), .q6(q[6]), .q7(q[7]),
        .wr_en(wr_en), .wr_data(wr_data),
        .bus_out(bus_out), .bus_valid(bus_valid), .bus_tag(bus_tag),
        .busy(busy), .done(done), .sel_err(sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", tag, cycle, actual, expected);
        end
    endtask

    function automatic logic [15:0] ref_value(input logic [7:0] s);
        if ($countones(wr_en) == 1 && wr_en == s) return wr_data;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) return q[i];
        end
        return 16'h0000;
    endfunction

    // Predict the outputs of the coming edge from the inputs now applied, then clock and compare.
    task automatic step();
        int  ph;
        logic good;
        ph   = since_acc + 1;
        good = ($countones(sel_a) == 1) && ($countones(sel_b) == 1);
        if (!resetn) begin
            {exp_out, exp_valid, exp_tag, exp_busy, exp_done, exp_err} = '0;
            since_acc = 99;
        end else begin
            exp_valid = (ph == 1) || (ph == 2);
            exp_out   = (ph == 1) ? ref_value(lat_a) : (ph == 2) ? ref_value(lat_b) : 16'h0000;
            exp_tag   = (ph == 2);
            exp_done  = (ph == 2);
            exp_err   = start && (ph >= 3) && !good;
            exp_busy  = (ph == 1);
            if (start && good && ph >= 2) begin
                lat_a     = sel_a;
                lat_b     = sel_b;
                since_acc = 0;
                exp_busy  = 1'b1;
            end else begin
                since_acc = (ph > 99) ? 99 : ph;
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        checkOutput("bus_out", 32'(bus_out), 32'(exp_out));
        checkOutput("bus_valid", 32'(bus_valid), 32'(exp_valid));
        checkOutput("bus_tag", 32'(bus_tag), 32'(exp_tag));
        checkOutput("busy", 32'(busy), 32'(exp_busy));
        checkOutput("done", 32'(done), 32'(exp_done));
        checkOutput("sel_err", 32'(sel_err), 32'(exp_err));
        checkOutput("err_done_excl", 32'(sel_err & done), 32'd0);
    endtask

    task automatic applyStimulus(input logic st, input logic [7:0] sa, input logic [7:0] sb,
                                 input logic [7:0] we, input logic [15:0] wd, input logic rn);
        start   = st;
        sel_a   = sa;
        sel_b   = sb;
        wr_en   = we;
        wr_data = wd;
        resetn  = rn;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) q[i] = 16'h1000 + 16'(i);
        start = 0; sel_a = 0; sel_b = 0; wr_en = 0; wr_data = 0; resetn = 0;

        $display("[TB] reset");
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0);
        applyStimulus(1'b1, 8'h01, 8'h02, 8'h00, 16'h0000, 1'b0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        idle(2);

        $display("[TB] basic read");
        q[2] = 16'h1234; q[5] = 16'hBEEF;
        applyStimulus(1'b1, 8'h04, 8'h20, 8'h00, 16'h0000, 1'b1);
        checkOutput("basic_busy_n", 32'(busy), 32'd1);
        idle(1);
        checkOutput("basic_a", 32'(bus_out), 32'h1234);
        idle(1);
        checkOutput("basic_b", 32'(bus_out), 32'hBEEF);
        checkOutput("basic_done", 32'(done), 32'd1);
        checkOutput("basic_busy_low", 32'(busy), 32'd0);
        idle(2);

        $display("[TB] forwarding");
        q[3] = 16'h0001;
        applyStimulus(1'b1, 8'h08, 8'h20, 8'h00, 16'h0000, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h08, 16'hAAAA, 1'b1);
        checkOutput("fwd_a", 32'(bus_out), 32'hAAAA);
        idle(2);
        applyStimulus(1'b1, 8'h08, 8'h20, 8'h00, 16'h0000, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h09, 16'hAAAA, 1'b1);
        checkOutput("nofwd_multihot", 32'(bus_out), 32'h0001);
        idle(2);

        $display("[TB] bad select");
        applyStimulus(1'b1, 8'h00, 8'h20, 8'h00, 16'h0000, 1'b1);
        checkOutput("bad_a_err", 32'(sel_err), 32'd1);
        idle(1);
        checkOutput("bad_a_pulse", 32'(sel_err), 32'd0);
        applyStimulus(1'b1, 8'h04, 8'h03, 8'h00, 16'h0000, 1'b1);
        checkOutput("bad_b_err", 32'(sel_err), 32'd1);
        idle(2);

        $display("[TB] back-to-back");
        q[0] = 16'h0F0F; q[7] = 16'hF0F0;
        applyStimulus(1'b1, 8'h04, 8'h20, 8'h00, 16'h0000, 1'b1);
        applyStimulus(1'b1, 8'h02, 8'h02, 8'h00, 16'h0000, 1'b1);
        applyStimulus(1'b1, 8'h01, 8'h80, 8'h00, 16'h0000, 1'b1);
        checkOutput("b2b_b1", 32'(bus_out), 32'hBEEF);
        idle(1);
        checkOutput("b2b_a2", 32'(bus_out), 32'h0F0F);
        idle(1);
        checkOutput("b2b_b2", 32'(bus_out), 32'hF0F0);
        idle(2);

        $display("[TB] same source");
        q[6] = 16'h7777;
        applyStimulus(1'b1, 8'h40, 8'h40, 8'h00, 16'h0000, 1'b1);
        idle(1);
        checkOutput("same_a", 32'({bus_out, bus_tag}), 32'({16'h7777, 1'b0}));
        idle(1);
        checkOutput("same_b", 32'({bus_out, bus_tag}), 32'({16'h7777, 1'b1}));
        idle(2);

        $display("[TB] reset mid-op");
        applyStimulus(1'b1, 8'h04, 8'h20, 8'h00, 16'h0000, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0);
        checkOutput("midrst_valid", 32'(bus_valid), 32'd0);
        idle(2);
        checkOutput("midrst_nob", 32'(bus_valid), 32'd0);
        applyStimulus(1'b1, 8'h20, 8'h04, 8'h00, 16'h0000, 1'b1);
        idle(1);
        checkOutput("midrst_fresh_a", 32'(bus_out), 32'hBEEF);
        idle(2);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            logic [7:0]  sa, sb, we;
            logic [15:0] wd;
            sa = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            sb = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       we = 8'h00;
                1:       we = 8'($urandom);
                default: we = 8'(1 << $urandom_range(0, 7));
            endcase
            wd = 16'($urandom);
            if ($urandom_range(0, 3) == 0) q[$urandom_range(0, 7)] = 16'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), sa, sb, we, wd, ($urandom_range(0, 49) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
